// File: rtl/ide_pkg.sv
// Shared ATA definitions: task-file register addresses ({cs, da}), status bit
// positions, command codes and error codes. Imported by the device and host sides.
package ide_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] REG_DATA    = 5'b10000;
    localparam logic [ADDR_W-1:0] REG_ERROR   = 5'b10001;  // read ERROR, write FEATURE
    localparam logic [ADDR_W-1:0] REG_SECCNT  = 5'b10010;
    localparam logic [ADDR_W-1:0] REG_SECNUM  = 5'b10011;
    localparam logic [ADDR_W-1:0] REG_CYLLOW  = 5'b10100;
    localparam logic [ADDR_W-1:0] REG_CYLHIGH = 5'b10101;
    localparam logic [ADDR_W-1:0] REG_DRVHEAD = 5'b10110;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 5'b10111;  // read STATUS, write COMMAND
    localparam logic [ADDR_W-1:0] REG_ALTER   = 5'b01110;  // read ALTER, write DEVCTRL

    localparam int unsigned ST_BSY  = 7;
    localparam int unsigned ST_DRDY = 6;
    localparam int unsigned ST_DSC  = 4;
    localparam int unsigned ST_DRQ  = 3;
    localparam int unsigned ST_ERR  = 0;

    localparam int unsigned DEVCTRL_SRST = 2;
    localparam int unsigned DRVHEAD_DEV  = 4;

    localparam logic [7:0] CMD_READ_SECTOR  = 8'h20;
    localparam logic [7:0] CMD_WRITE_SECTOR = 8'h30;

    localparam logic [7:0] ERR_ABRT = 8'h04;
    localparam logic [7:0] ERR_UNC  = 8'h40;

endpackage

// File: rtl/ide_sector_buf.sv
// 256x16 dual-port sector buffer, synchronous reads on both ports.
// Port A faces the IDE host, port B the backing store.
module ide_sector_buf
    import ide_pkg::*;
(
    input  logic        clk,
    input  logic [7:0]  a_addr,
    input  logic        a_we,
    input  logic [15:0] a_wdata,
    output logic [15:0] a_rdata,
    input  logic [7:0]  b_addr,
    input  logic        b_we,
    input  logic [15:0] b_wdata,
    output logic [15:0] b_rdata
);

    logic [DATA_W-1:0] mem [256];

    // Writes from both ports; port B wins a same-address collision.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    // Registered reads, one cycle of latency on each port.
    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/ide_target.sv
// IDE/ATA device-side responder: task-file registers, status, and one-sector
// PIO transfers through ide_sector_buf, filled/drained by a backing store.
// Build option IDE_TARGET_SYNC_EN: adds two-flop synchronizers on dior/diow/cs/da.
module ide_target
    import ide_pkg::*;
#(
    parameter logic        DEV_SEL  = 1'b0,
    parameter int unsigned BUSY_MIN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ide_data_in,
    output logic [15:0] ide_data_out,
    output logic        ide_data_oe,
    input  logic        ide_dior,
    input  logic        ide_diow,
    input  logic [1:0]  ide_cs,
    input  logic [2:0]  ide_da,
    output logic        store_req,
    output logic        store_write,
    output logic [23:0] store_lba,
    input  logic        store_ack,
    input  logic        store_err,
    input  logic [7:0]  buf_addr,
    input  logic        buf_we,
    input  logic [15:0] buf_wdata,
    output logic [15:0] buf_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_FETCH, S_RD_DRQ, S_WR_DRQ, S_WR_FLUSH, S_RST
    } state_t;

    state_t state, state_n;

    logic              dior_in, diow_in;
    logic [ADDR_W-1:0] addr_in;
    logic              dior_q, diow_q, dior_p, diow_p;
    logic [ADDR_W-1:0] addr_q, addr_hold;
    logic [DATA_W-1:0] wdata;

`ifdef IDE_TARGET_SYNC_EN
    logic              dior_s1, dior_s2, diow_s1, diow_s2;
    logic [ADDR_W-1:0] addr_s1, addr_s2;

    // Two-flop synchronizers for asynchronous host pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            dior_s1 <= 1'b1;
            dior_s2 <= 1'b1;
            diow_s1 <= 1'b1;
            diow_s2 <= 1'b1;
            addr_s1 <= '0;
            addr_s2 <= '0;
        end else begin
            dior_s1 <= ide_dior;
            dior_s2 <= dior_s1;
            diow_s1 <= ide_diow;
            diow_s2 <= diow_s1;
            addr_s1 <= {ide_cs, ide_da};
            addr_s2 <= addr_s1;
        end
    end

    assign dior_in = dior_s2;
    assign diow_in = diow_s2;
    assign addr_in = addr_s2;
`else
    assign dior_in = ide_dior;
    assign diow_in = ide_diow;
    assign addr_in = {ide_cs, ide_da};
`endif

    // Strobe/address capture; address and write data are held from the strobe-low phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            dior_q    <= 1'b1;
            diow_q    <= 1'b1;
            dior_p    <= 1'b1;
            diow_p    <= 1'b1;
            addr_q    <= '0;
            addr_hold <= '0;
            wdata     <= '0;
        end else begin
            dior_q <= dior_in;
            diow_q <= diow_in;
            dior_p <= dior_q;
            diow_p <= diow_q;
            addr_q <= addr_in;
            if (!dior_q || !diow_q) addr_hold <= addr_q;
            if (!ide_diow) wdata <= ide_data_in;
        end
    end

    logic        rd_ev, wr_ev, data_rd, data_wr, cmd_wr, ctrl_wr;
    logic        dev_match, busy_done, last_word, rd_sel;
    logic        err, err_n, ack_seen;
    logic [7:0]  error, error_n, feature, seccnt, secnum, cyllow, cylhigh, drvhead, devctrl;
    logic [7:0]  wc, status;
    logic [15:0] busy_cnt;
    logic [DATA_W-1:0] a_rdata, rd_mux;

    assign rd_ev     = dior_q && !dior_p;
    assign wr_ev     = diow_q && !diow_p;
    assign data_rd   = rd_ev && (addr_hold == REG_DATA);
    assign data_wr   = wr_ev && (addr_hold == REG_DATA);
    assign dev_match = (drvhead[DRVHEAD_DEV] == DEV_SEL);
    assign cmd_wr    = wr_ev && (addr_hold == REG_STATUS) && dev_match;
    assign ctrl_wr   = wr_ev && (addr_hold == REG_ALTER);
    assign busy_done = (32'(busy_cnt) + 32'd1) >= BUSY_MIN;
    assign last_word = (wc == 8'hFF);

    // Command/transfer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            err   <= 1'b0;
            error <= '0;
        end else begin
            state <= state_n;
            err   <= err_n;
            error <= error_n;
        end
    end

    // Next state and error bookkeeping; soft reset overrides everything, including an ack.
    always_comb begin
        state_n = state;
        err_n   = err;
        error_n = error;
        if (ctrl_wr && wdata[DEVCTRL_SRST]) begin
            state_n = S_RST;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_wr) begin
                        err_n   = 1'b0;
                        error_n = '0;
                        case (wdata[7:0])
                            CMD_READ_SECTOR:  state_n = S_RD_FETCH;
                            CMD_WRITE_SECTOR: state_n = S_WR_DRQ;
                            default: begin
                                err_n   = 1'b1;
                                error_n = ERR_ABRT;
                            end
                        endcase
                    end
                end
                S_RD_FETCH: begin
                    if (store_ack && store_err) begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                        error_n = ERR_UNC;
                    end else if ((ack_seen || store_ack) && busy_done) begin
                        state_n = S_RD_DRQ;
                    end
                end
                S_RD_DRQ:   if (data_rd && last_word) state_n = S_IDLE;
                S_WR_DRQ:   if (data_wr && last_word) state_n = S_WR_FLUSH;
                S_WR_FLUSH: begin
                    if (store_ack) begin
                        state_n = S_IDLE;
                        if (store_err) begin
                            err_n   = 1'b1;
                            error_n = ERR_UNC;
                        end
                    end
                end
                S_RST: begin
                    if (ctrl_wr) begin
                        state_n = S_IDLE;
                        err_n   = 1'b0;
                        error_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Word counter, busy timer, backing-store handshake and task-file registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wc          <= '0;
            busy_cnt    <= '0;
            ack_seen    <= 1'b0;
            store_req   <= 1'b0;
            store_write <= 1'b0;
            store_lba   <= '0;
            feature     <= '0;
            seccnt      <= '0;
            secnum      <= '0;
            cyllow      <= '0;
            cylhigh     <= '0;
            drvhead     <= '0;
            devctrl     <= '0;
        end else begin
            if (state_n != S_RD_DRQ && state_n != S_WR_DRQ) begin
                wc <= '0;
            end else if ((state == S_RD_DRQ && data_rd) || (state == S_WR_DRQ && data_wr)) begin
                wc <= wc + 8'd1;
            end
            if (state != S_RD_FETCH) begin
                busy_cnt <= '0;
            end else if (busy_cnt != '1) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
            ack_seen    <= (state_n == S_RD_FETCH) && (ack_seen || store_ack);
            store_req   <= ((state_n == S_RD_FETCH) && !ack_seen && !store_ack)
                           || (state_n == S_WR_FLUSH);
            store_write <= (state_n == S_WR_FLUSH);
            store_lba   <= {cylhigh, cyllow, secnum};
            if (wr_ev) begin
                case (addr_hold)
                    REG_ERROR:   feature <= wdata[7:0];
                    REG_SECCNT:  seccnt  <= wdata[7:0];
                    REG_SECNUM:  secnum  <= wdata[7:0];
                    REG_CYLLOW:  cyllow  <= wdata[7:0];
                    REG_CYLHIGH: cylhigh <= wdata[7:0];
                    REG_DRVHEAD: drvhead <= wdata[7:0];
                    REG_ALTER:   devctrl <= wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    // FEATURE and nIEN are write-only storage with no behaviour attached.
    logic unused_bits;
    assign unused_bits = ^{feature, devctrl};

    // Status byte as seen by the host.
    always_comb begin
        status = '0;
        case (state)
            S_IDLE: begin
                status[ST_DRDY] = 1'b1;
                status[ST_DSC]  = 1'b1;
                status[ST_ERR]  = err;
            end
            S_RD_DRQ, S_WR_DRQ: begin
                status[ST_DRDY] = 1'b1;
                status[ST_DSC]  = 1'b1;
                status[ST_DRQ]  = 1'b1;
            end
            default: status[ST_BSY] = 1'b1;
        endcase
    end

    // Register read mux; only DATA uses the upper byte.
    always_comb begin
        rd_mux = '0;
        case (addr_q)
            REG_DATA:              if (state == S_RD_DRQ) rd_mux = a_rdata;
            REG_ERROR:             rd_mux = {8'h00, error};
            REG_SECCNT:            rd_mux = {8'h00, seccnt};
            REG_SECNUM:            rd_mux = {8'h00, secnum};
            REG_CYLLOW:            rd_mux = {8'h00, cyllow};
            REG_CYLHIGH:           rd_mux = {8'h00, cylhigh};
            REG_DRVHEAD:           rd_mux = {8'h00, drvhead};
            REG_STATUS, REG_ALTER: if (dev_match) rd_mux = {8'h00, status};
            default: ;
        endcase
    end

    assign rd_sel = !dior_q && (addr_q[ADDR_W-1 -: 2] != 2'b11);

    // Registered pad data and drive enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            ide_data_oe  <= 1'b0;
            ide_data_out <= '0;
        end else begin
            ide_data_oe  <= rd_sel;
            ide_data_out <= rd_sel ? rd_mux : '0;
        end
    end

    ide_sector_buf u_buf (
        .clk     (clk),
        .a_addr  (wc),
        .a_we    (state == S_WR_DRQ && data_wr),
        .a_wdata (wdata),
        .a_rdata (a_rdata),
        .b_addr  (buf_addr),
        .b_we    (buf_we),
        .b_wdata (buf_wdata),
        .b_rdata (buf_rdata)
    );

endmodule
